// File: rtl/account_db_responder_pkg.sv
// Shared types for the ATM account database responder: op codes, status codes, FSM states.
package atm_db_pkg;

  localparam int N_ENTRIES_DEF = 16;
  localparam int W_DEF         = 4;
  localparam int INIT_BAL_DEF  = 15;

  typedef enum logic [1:0] {
    OP_FIND     = 2'd0,
    OP_SET_BAL  = 2'd1,
    OP_CHG_PASS = 2'd2,
    OP_TRANSFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK             = 3'd0,
    ST_NOT_FOUND      = 3'd1,
    ST_BAD_PASS       = 3'd2,
    ST_INSUFFICIENT   = 3'd3,
    ST_OVERFLOW       = 3'd4,
    ST_DEST_NOT_FOUND = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/account_db_responder_if.sv
// Request/response channels between the ATM controller (master) and the account database (slave).
interface account_db_if #(parameter int W = 4);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_card;
  logic [W-1:0] req_pass;
  logic [W-1:0] req_data;
  logic [W-1:0] req_dest;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2:0]   rsp_status;
  logic [W-1:0] rsp_balance;

  modport master (
    output req_valid, req_op, req_card, req_pass, req_data, req_dest, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_card, req_pass, req_data, req_dest, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance
  );
endinterface

// File: rtl/account_db_responder_table.sv
// Account table: card/pass/bal arrays, one combinational read port, two write ports; writes land next edge.
// No backpressure; port 2 only ever writes a balance and never the same entry as port 1.
module account_table #(
  parameter int N_ENTRIES = 16,
  parameter int W         = 4,
  parameter int INIT_BAL  = 15,
  parameter int IW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_card,
  output logic [W-1:0]  rd_pass,
  output logic [W-1:0]  rd_bal,
  input  logic          wr_en,
  input  logic          wr_pass,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          wr2_en,
  input  logic [IW-1:0] wr2_idx,
  input  logic [W-1:0]  wr2_data
);

  logic [W-1:0] card [N_ENTRIES];
  logic [W-1:0] pass [N_ENTRIES];
  logic [W-1:0] bal  [N_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        card[i] <= W'(i + 1);
        pass[i] <= W'(i + 1);
        bal[i]  <= W'(INIT_BAL);
      end
    end else begin
      if (wr_en) begin
        if (wr_pass) pass[wr_idx] <= wr_data;
        else         bal[wr_idx]  <= wr_data;
      end
      if (wr2_en) bal[wr2_idx] <= wr2_data;
    end
  end

  assign rd_card = card[rd_idx];
  assign rd_pass = pass[rd_idx];
  assign rd_bal  = bal[rd_idx];

endmodule

// File: rtl/account_db_responder.sv
// Account DB responder: full fixed-length scan, response N_ENTRIES+1 cycles after accept (+1 for a committed transfer).
// One request in flight; req_ready only in IDLE, response held until rsp_ready.
module account_db_responder
  import atm_db_pkg::*;
#(
  parameter int N_ENTRIES = N_ENTRIES_DEF,
  parameter int W         = W_DEF,
  parameter int INIT_BAL  = INIT_BAL_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  account_db_if.slave  db
);

  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int CW = IW + 1;

  state_e        state, state_nxt;
  logic [CW-1:0] idx;
  op_e           op_q;
  logic [W-1:0]  card_q, pass_q, data_q, dest_q;
  logic          src_hit, dst_hit;
  logic [IW-1:0] src_idx, dst_idx;
  logic [W-1:0]  src_pass, src_bal, dst_bal;
  logic [W-1:0]  rd_card, rd_pass, rd_bal;
  logic          rsp_valid_q;
  status_e       rsp_status_q;
  logic [W-1:0]  rsp_balance_q;

  logic          wr_en, wr_pass, wr2_en;
  logic [IW-1:0] wr_idx, wr2_idx;
  logic [W-1:0]  wr_data, wr2_data;

  status_e       eval_status;
  logic [W-1:0]  eval_bal;
  logic          go_commit;

  logic          accept, rsp_fire, scan_done, pass_ok, self_xfer;
  logic [W:0]    dst_sum;

  assign accept    = db.req_valid && (state == S_IDLE);
  assign rsp_fire  = rsp_valid_q && db.rsp_ready;
  assign scan_done = (idx == CW'(N_ENTRIES));
  assign pass_ok   = (src_pass == pass_q);
  assign self_xfer = (src_idx == dst_idx);
  assign dst_sum   = {1'b0, dst_bal} + {1'b0, data_q};

  account_table #(
    .N_ENTRIES (N_ENTRIES),
    .W         (W),
    .INIT_BAL  (INIT_BAL),
    .IW        (IW)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx[IW-1:0]),
    .rd_card  (rd_card),
    .rd_pass  (rd_pass),
    .rd_bal   (rd_bal),
    .wr_en    (wr_en),
    .wr_pass  (wr_pass),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr2_en   (wr2_en),
    .wr2_idx  (wr2_idx),
    .wr2_data (wr2_data)
  );

  // Verdict from latched scan results; transfer checks are in priority order.
  always_comb begin
    eval_status = ST_OK;
    eval_bal    = src_bal;
    go_commit   = 1'b0;
    if (!src_hit) begin
      eval_status = ST_NOT_FOUND;
      eval_bal    = '0;
    end else begin
      case (op_q)
        OP_FIND:     if (!pass_ok) eval_status = ST_BAD_PASS;
        OP_SET_BAL:  eval_bal = data_q;
        OP_CHG_PASS: if (!pass_ok) eval_status = ST_BAD_PASS;
        OP_TRANSFER: begin
          if (!pass_ok)              eval_status = ST_BAD_PASS;
          else if (!dst_hit)         eval_status = ST_DEST_NOT_FOUND;
          else if (data_q > src_bal) eval_status = ST_INSUFFICIENT;
          else if (dst_sum[W])       eval_status = ST_OVERFLOW;
          else                       go_commit   = 1'b1;
        end
        default: eval_status = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_pass   = 1'b0;
    wr_idx    = src_idx;
    wr_data   = data_q;
    wr2_en    = 1'b0;
    wr2_idx   = dst_idx;
    wr2_data  = dst_sum[W-1:0];
    case (state)
      S_IDLE: if (accept) state_nxt = S_SCAN;
      S_SCAN: begin
        if (scan_done) begin
          state_nxt = go_commit ? S_COMMIT : S_RESP;
          if (src_hit && op_q == OP_SET_BAL) wr_en = 1'b1;
          if (src_hit && op_q == OP_CHG_PASS && pass_ok) begin
            wr_en   = 1'b1;
            wr_pass = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        state_nxt = S_RESP;
        if (!self_xfer) begin
          wr_en   = 1'b1;
          wr_data = src_bal - data_q;
          wr2_en  = 1'b1;
        end
      end
      S_RESP: if (rsp_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      op_q          <= OP_FIND;
      card_q        <= '0;
      pass_q        <= '0;
      data_q        <= '0;
      dest_q        <= '0;
      src_hit       <= 1'b0;
      dst_hit       <= 1'b0;
      src_idx       <= '0;
      dst_idx       <= '0;
      src_pass      <= '0;
      src_bal       <= '0;
      dst_bal       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(db.req_op);
        card_q  <= db.req_card;
        pass_q  <= db.req_pass;
        data_q  <= db.req_data;
        dest_q  <= db.req_dest;
        idx     <= '0;
        src_hit <= 1'b0;
        dst_hit <= 1'b0;
      end
      if (state == S_SCAN && !scan_done) begin
        idx <= idx + 1'b1;
        if (!src_hit && rd_card == card_q) begin
          src_hit  <= 1'b1;
          src_idx  <= idx[IW-1:0];
          src_pass <= rd_pass;
          src_bal  <= rd_bal;
        end
        if (!dst_hit && rd_card == dest_q) begin
          dst_hit <= 1'b1;
          dst_idx <= idx[IW-1:0];
          dst_bal <= rd_bal;
        end
      end
      if (state == S_SCAN && scan_done && !go_commit) begin
        rsp_valid_q   <= 1'b1;
        rsp_status_q  <= eval_status;
        rsp_balance_q <= eval_bal;
      end
      if (state == S_COMMIT) begin
        rsp_valid_q   <= 1'b1;
        rsp_status_q  <= ST_OK;
        rsp_balance_q <= self_xfer ? src_bal : src_bal - data_q;
      end
      if (rsp_fire) rsp_valid_q <= 1'b0;
    end
  end

  assign db.req_ready   = (state == S_IDLE);
  assign db.rsp_valid   = rsp_valid_q;
  assign db.rsp_status  = rsp_status_q;
  assign db.rsp_balance = rsp_balance_q;

endmodule
